// File: rtl/memory_pkg.sv
// Shared types and constants for the main store and its access controller.
package memory_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 31;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Instruction word layout: sign | operator | first address | second address
  localparam int SIGN_BIT = 30;
  localparam int OP_HI    = 29;
  localparam int OP_LO    = 24;
  localparam int A1_HI    = 23;
  localparam int A1_LO    = 12;
  localparam int A2_HI    = 11;
  localparam int A2_LO    = 0;

  function automatic logic [5:0] word_op(input word_t w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/memory_array.sv
// Storage array: one synchronous write port, one read port registered into the output word.
module memory_array
  import memory_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  logic  re,
  input  addr_t raddr,
  output word_t rdata
);

  // Contents survive reset; only the read register is cleared.
  word_t mem_r [0:DEPTH-1];
  word_t rd_data_d, rd_data_q;

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem_r[waddr] <= wdata;
  end

  // Read register keeps its word until the next read strobe.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem_r[raddr];
  end

  // Read register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/memory_unit.sv
// Main store access controller: fixed-latency read/write with a preload side port.
//
// state | meaning
// IDLE  | accepting one request pulse or a preload strobe
// WAIT  | access latched, counting down to the reply edge
module memory_unit
  import memory_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_read_pulse,
  input  logic              mem_write_pulse,
  output logic              mem_reply,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_busy,
  output logic              mem_error,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_state_t state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  addr_t      addr_d, addr_q;
  word_t      wdata_d, wdata_q;
  logic       is_wr_d, is_wr_q;
  logic       reply_d, reply_q;
  logic       busy_d, busy_q;
  logic       error_d, error_q;

  logic       any_req, one_req;
  logic       arr_we, arr_re;
  addr_t      arr_waddr;
  word_t      arr_wdata;

  assign any_req = mem_read_pulse | mem_write_pulse;
  assign one_req = mem_read_pulse ^ mem_write_pulse;

  // Next-state, request latching, error detection and array port steering.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    busy_d    = busy_q;
    reply_d   = 1'b0;
    error_d   = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_waddr = addr_q;
    arr_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_read_pulse && mem_write_pulse) begin
          error_d = 1'b1;
        end else if (one_req) begin
          addr_d  = mem_addr;
          wdata_d = mem_data_in;
          is_wr_d = mem_write_pulse;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
          busy_d  = 1'b1;
        end
        // A preload colliding with any request pulse is dropped and flagged.
        if (load_en) begin
          if (any_req) begin
            error_d = 1'b1;
          end else begin
            arr_we    = 1'b1;
            arr_waddr = load_addr;
            arr_wdata = load_data;
          end
        end
      end
      WAIT: begin
        if (any_req || load_en) error_d = 1'b1;
        if (cnt_q == 4'd0) begin
          reply_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (is_wr_q) arr_we = 1'b1;
          else         arr_re = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers with synchronous reset; reset aborts any pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      reply_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      reply_q <= reply_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  // Reset must win over a write or read landing on the same edge.
  memory_array u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we & ~rst),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re & ~rst),
    .raddr (addr_q),
    .rdata (mem_data_out)
  );

  assign mem_reply = reply_q;
  assign mem_busy  = busy_q;
  assign mem_error = error_q;

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: LATENCY=3 instance plus a LATENCY=1 instance.
module tb_memory_unit;
  import memory_pkg::*;

  localparam word_t D1 = {1'b0, 6'o00, 12'o1111, 12'o2222};
  localparam word_t D2 = {1'b0, 6'o33, 12'o3333, 12'o3333};
  localparam word_t D3 = {1'b0, 6'o55, 12'o5555, 12'o5555};
  localparam word_t D4 = {1'b0, 6'o44, 12'o4444, 12'o4444};
  localparam word_t D5 = {1'b1, 6'o12, 12'o0123, 12'o4567};
  localparam word_t D6 = {1'b0, 6'o77, 12'o7654, 12'o3210};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst;
  addr_t a_addr, a_ld_addr, b_addr, b_ld_addr;
  word_t a_din, a_ld_data, a_dout, b_din, b_ld_data, b_dout;
  logic  a_rd, a_wr, a_ld, a_reply, a_busy, a_err;
  logic  b_rd, b_wr, b_ld, b_reply, b_busy, b_err;

  memory_unit #(.LATENCY(3)) dut_a (
    .clk(clk), .rst(rst), .mem_addr(a_addr), .mem_data_in(a_din),
    .mem_read_pulse(a_rd), .mem_write_pulse(a_wr), .mem_reply(a_reply),
    .mem_data_out(a_dout), .mem_busy(a_busy), .mem_error(a_err),
    .load_en(a_ld), .load_addr(a_ld_addr), .load_data(a_ld_data)
  );

  memory_unit #(.LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_data_in(b_din),
    .mem_read_pulse(b_rd), .mem_write_pulse(b_wr), .mem_reply(b_reply),
    .mem_data_out(b_dout), .mem_busy(b_busy), .mem_error(b_err),
    .load_en(b_ld), .load_addr(b_ld_addr), .load_data(b_ld_data)
  );

  typedef struct {
    word_t data;
    int    cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for instance A: every reply must match the oldest expectation.
  always @(negedge clk) begin
    if (a_reply === 1'b1) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_spurious_reply: reply at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_reply_data", a_dout, e.data);
        chk("a_reply_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (b_reply === 1'b1) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_spurious_reply: reply at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_reply_data", b_dout, e.data);
        chk("b_reply_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge; the pulse is sampled at the next edge (E0).
  task automatic a_req(input logic rd, input logic wr, input addr_t ad, input word_t d,
                       input logic push, input word_t exp);
    a_rd = rd; a_wr = wr; a_addr = ad; a_din = d;
    if (push) qa.push_back('{data: exp, cyc: cyc + 1 + 3});
    @(negedge clk);
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  task automatic b_req(input addr_t ad, input word_t exp);
    b_rd = 1'b1; b_addr = ad;
    qb.push_back('{data: exp, cyc: cyc + 1 + 1});
    @(negedge clk);
    b_rd = 1'b0;
  endtask

  task automatic a_load(input addr_t ad, input word_t d);
    a_ld = 1'b1; a_ld_addr = ad; a_ld_data = d;
    @(negedge clk);
    a_ld = 1'b0;
  endtask

  task automatic b_load(input addr_t ad, input word_t d);
    b_ld = 1'b1; b_ld_addr = ad; b_ld_data = d;
    @(negedge clk);
    b_ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_addr = '0; a_din = '0; a_rd = 1'b0; a_wr = 1'b0;
    a_ld = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    b_addr = '0; b_din = '0; b_rd = 1'b0; b_wr = 1'b0;
    b_ld = 1'b0; b_ld_addr = '0; b_ld_data = '0;
    ticks(2);
    chk("rst_reply", a_reply, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_error", a_err, 0);
    chk("rst_b_reply", b_reply, 0);
    chk("rst_b_dout", b_dout, 0);
    rst = 1'b0;
    ticks(1);

    // Preload and read with busy window E0..E0+2
    a_load(12'o0001, D1);
    a_req(1'b1, 1'b0, 12'o0001, '0, 1'b1, D1);
    chk("rd_busy_e0", a_busy, 1);
    chk("rd_err_e0", a_err, 0);
    ticks(1);
    chk("rd_busy_e1", a_busy, 1);
    ticks(1);
    chk("rd_busy_e2", a_busy, 1);
    ticks(1);
    chk("rd_busy_reply", a_busy, 0);
    ticks(1);

    // Write then read back; write reply leaves the output word alone
    a_req(1'b0, 1'b1, 12'o0100, D2, 1'b1, D1);
    ticks(4);
    a_req(1'b1, 1'b0, 12'o0100, '0, 1'b1, D2);
    ticks(4);

    // Collision while busy
    a_req(1'b1, 1'b0, 12'o0001, '0, 1'b1, D1);
    chk("coll_err_e0", a_err, 0);
    a_req(1'b1, 1'b0, 12'o0002, '0, 1'b0, '0);
    chk("coll_err_e1", a_err, 1);
    ticks(1);
    chk("coll_err_e2", a_err, 0);
    ticks(3);

    // Dual pulse in IDLE: error, no access
    a_load(12'o0200, D3);
    a_req(1'b1, 1'b1, 12'o0200, D4, 1'b0, '0);
    chk("dual_err", a_err, 1);
    chk("dual_busy", a_busy, 0);
    ticks(1);
    chk("dual_err_clear", a_err, 0);
    ticks(8);

    // Reset two edges into a pending write
    a_req(1'b0, 1'b1, 12'o0200, D4, 1'b0, '0);
    ticks(1);
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    chk("rstw_reply", a_reply, 0);
    chk("rstw_dout", a_dout, 0);
    chk("rstw_busy", a_busy, 0);
    chk("rstw_error", a_err, 0);
    ticks(8);
    a_req(1'b1, 1'b0, 12'o0200, '0, 1'b1, D3);
    ticks(4);

    // Preload during WAIT is rejected
    a_req(1'b1, 1'b0, 12'o0001, '0, 1'b1, D1);
    a_load(12'o0100, D5);
    chk("ld_wait_err", a_err, 1);
    ticks(3);
    a_req(1'b1, 1'b0, 12'o0100, '0, 1'b1, D2);
    ticks(4);

    // Back-to-back: second read sampled in the reply cycle
    a_req(1'b1, 1'b0, 12'o0001, '0, 1'b1, D1);
    ticks(3);
    a_req(1'b1, 1'b0, 12'o0100, '0, 1'b1, D2);
    chk("b2b_err", a_err, 0);
    chk("b2b_busy", a_busy, 1);
    ticks(4);

    // Back-to-back with LATENCY=1
    b_load(12'o0005, D5);
    b_load(12'o0006, D6);
    b_req(12'o0005, D5);
    chk("l1_busy_e0", b_busy, 1);
    ticks(1);
    b_req(12'o0006, D6);
    chk("l1_b2b_err", b_err, 0);
    chk("l1_b2b_busy", b_busy, 1);
    ticks(2);

    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    chk("a_pending_replies", qa.size(), 0);
    chk("b_pending_replies", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
